sm_addsub_bcd_unit: RTL and testbench

//  Next-generation signed-magnitude add/subtract unit for the switch/7-seg lab boards, parametrised in width.

---
 rtl/sm_addsub_bcd_unit.sv | 165 ++++++++++++++++
 tb/tb_sm_addsub_bcd_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sm_addsub_bcd_unit.sv
// Signed-magnitude add/subtract/accumulate unit with sequential double-dabble BCD conversion.
// A key1 falling edge starts one operation; results and BCD digits update together with the done pulse.
module sm_addsub_bcd_unit #(
  parameter int W      = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  key0,
  input  logic                  key1,
  input  logic [W-1:0]          a_sm,
  input  logic [W-1:0]          b_sm,
  input  logic [1:0]            mode,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic                  neg,
  output logic [W-2:0]          res_mag,
  output logic [4*DIGITS-1:0]   bcd
);

  typedef enum logic [1:0] {IDLE, CALC, CONV, DONE} state_t;

  localparam int CW = $clog2(W);
  localparam logic [W-2:0] MAG_MAX = '1;

  state_t state, state_next;

  logic                 key1_q;
  logic                 trigger;
  logic [W-1:0]         a_q, b_q;
  logic [1:0]           mode_q;
  logic [W-1:0]         acc;
  logic                 r_ovf;
  logic [W-2:0]         shift_bin;
  logic [4*DIGITS-1:0]  bcd_work;
  logic [CW-1:0]        bit_cnt;
  logic                 conv_last;

  logic signed [W:0]    op_x, op_b, sum;
  logic [W:0]           sum_abs;
  logic                 calc_neg, calc_ovf;
  logic [W-2:0]         calc_mag;

  logic [3:0]           top_digit;
  logic [4*DIGITS-2:0]  adj;
  logic [4*DIGITS-1:0]  dabble_next;

  // Sign-magnitude to (W+1)-bit two's complement; negative zero collapses to zero naturally.
  function automatic logic signed [W:0] to_tc(input logic [W-1:0] x);
    logic signed [W:0] m;
    m = $signed({2'b00, x[W-2:0]});
    return x[W-1] ? -m : m;
  endfunction

  assign trigger   = key1_q & ~key1;
  assign conv_last = (bit_cnt == CW'(W-2));

  always_ff @(posedge clk or negedge key0) begin
    if (!key0) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (trigger) state_next = CALC;
      CALC:    state_next = CONV;
      CONV:    if (conv_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Signed arithmetic with saturation to the largest representable magnitude.
  always_comb begin
    op_x     = mode_q[1] ? to_tc(acc) : to_tc(a_q);
    op_b     = to_tc(b_q);
    sum      = mode_q[0] ? (op_x - op_b) : (op_x + op_b);
    calc_neg = sum[W];
    sum_abs  = calc_neg ? $unsigned(-sum) : $unsigned(sum);
    if (sum_abs > {2'b00, MAG_MAX}) begin
      calc_ovf = 1'b1;
      calc_mag = MAG_MAX;
    end else begin
      calc_ovf = 1'b0;
      calc_mag = sum_abs[W-2:0];
    end
  end

  // One double-dabble step; the top digit's carry-out can never be set for legal DIGITS.
  always_comb begin
    adj       = '0;
    top_digit = bcd_work[4*DIGITS-1 -: 4];
    for (int d = 0; d < DIGITS-1; d++) begin
      adj[4*d +: 4] = (bcd_work[4*d +: 4] >= 4'd5) ? (bcd_work[4*d +: 4] + 4'd3)
                                                    : bcd_work[4*d +: 4];
    end
    adj[4*DIGITS-2 -: 3] = (top_digit >= 4'd5) ? (top_digit[2:0] + 3'd3) : top_digit[2:0];
    dabble_next = {adj, shift_bin[W-2]};
  end

  always_ff @(posedge clk or negedge key0) begin
    if (!key0) begin
      key1_q <= 1'b0;
    end else begin
      key1_q <= key1;
    end
  end

  always_ff @(posedge clk or negedge key0) begin
    if (!key0) begin
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= '0;
      acc       <= '0;
      r_ovf     <= 1'b0;
      shift_bin <= '0;
      bcd_work  <= '0;
      bit_cnt   <= '0;
      ovf       <= 1'b0;
      neg       <= 1'b0;
      res_mag   <= '0;
      bcd       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            a_q    <= a_sm;
            b_q    <= b_sm;
            mode_q <= mode;
          end
        end
        CALC: begin
          acc       <= {calc_neg, calc_mag};
          r_ovf     <= calc_ovf;
          shift_bin <= calc_mag;
          bcd_work  <= '0;
          bit_cnt   <= '0;
        end
        CONV: begin
          bcd_work  <= dabble_next;
          shift_bin <= {shift_bin[W-3:0], 1'b0};
          bit_cnt   <= bit_cnt + 1'b1;
          if (conv_last) begin
            res_mag <= acc[W-2:0];
            neg     <= acc[W-1];
            ovf     <= r_ovf;
            bcd     <= dabble_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm_addsub_bcd_unit.sv
// Bench for sm_addsub_bcd_unit: directed vector table, randomized operations against a
// plain-integer model, and hand-written reset/abort/held-key sequences.
module tb_sm_addsub_bcd_unit;

  localparam int W      = 8;
  localparam int DIGITS = 3;

  logic                clk = 1'b0;
  logic                key0, key1;
  logic [W-1:0]        a_sm, b_sm;
  logic [1:0]          mode;
  logic                busy, done, ovf, neg;
  logic [W-2:0]        res_mag;
  logic [4*DIGITS-1:0] bcd;

  sm_addsub_bcd_unit #(.W(W), .DIGITS(DIGITS)) dut (
    .clk(clk), .key0(key0), .key1(key1), .a_sm(a_sm), .b_sm(b_sm), .mode(mode),
    .busy(busy), .done(done), .ovf(ovf), .neg(neg), .res_mag(res_mag), .bcd(bcd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  m;
    bit          rst_before;
    bit          glitch;
    int          e_mag;
    bit          e_neg;
    bit          e_ovf;
    logic [11:0] e_bcd;
  } vec_t;

  vec_t vecs[11];

  int checks = 0;
  int passed = 0;
  int model_acc = 0;
  int done_cycle, done_count, busy_cycles;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  function automatic int sm_val(input logic [7:0] x);
    return x[7] ? -int'(x[6:0]) : int'(x[6:0]);
  endfunction

  // Reference: integer arithmetic, saturation at 127, decimal digits by division.
  task automatic model_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                          output int e_mag, output bit e_neg, output bit e_ovf,
                          output logic [11:0] e_bcd);
    int x, r;
    x = m[1] ? model_acc : sm_val(a);
    r = m[0] ? (x - sm_val(b)) : (x + sm_val(b));
    e_neg = (r < 0);
    e_mag = e_neg ? -r : r;
    e_ovf = (e_mag > 127);
    if (e_ovf) e_mag = 127;
    model_acc = e_neg ? -e_mag : e_mag;
    e_bcd = 12'((e_mag / 100) * 256 + ((e_mag / 10) % 10) * 16 + (e_mag % 10));
  endtask

  task automatic do_reset();
    @(negedge clk);
    key0 = 1'b0;
    #2;
    @(negedge clk);
    key0 = 1'b1;
    model_acc = 0;
    @(negedge clk);
  endtask

  // Press key1, then watch a fixed window of cycles; cycle 1 is the one after the capturing edge.
  task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                                input bit glitch);
    @(negedge clk);
    a_sm = a;
    b_sm = b;
    mode = m;
    key1 = 1'b0;
    @(posedge clk);
    done_cycle  = 0;
    done_count  = 0;
    busy_cycles = 0;
    for (int c = 1; c <= W + 6; c++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        done_count++;
        if (done_cycle == 0) done_cycle = c;
      end
      if (c == 1) key1 = 1'b1;
      if (glitch && c == 2) key1 = 1'b0;
      if (glitch && c == 4) key1 = 1'b1;
    end
  endtask

  task automatic check_output(input string tag, input int e_mag, input bit e_neg,
                              input bit e_ovf, input logic [11:0] e_bcd);
    check({tag, ".done_cycle"}, done_cycle, W + 1);
    check({tag, ".done_count"}, done_count, 1);
    check({tag, ".busy_cycles"}, busy_cycles, W + 1);
    check({tag, ".res_mag"}, 32'(res_mag), e_mag);
    check({tag, ".neg"}, 32'(neg), 32'(e_neg));
    check({tag, ".ovf"}, 32'(ovf), 32'(e_ovf));
    check({tag, ".bcd"}, 32'(bcd), 32'(e_bcd));
  endtask

  initial begin
    int          e_mag;
    bit          e_neg, e_ovf;
    logic [11:0] e_bcd;
    logic [7:0]  ra, rb;
    logic [1:0]  rm;
    int          busy_seen;

    vecs[0]  = '{8'h19, 8'h8A, 2'b00, 1'b0, 1'b0,  15, 1'b0, 1'b0, 12'h015};
    vecs[1]  = '{8'h05, 8'h14, 2'b01, 1'b0, 1'b0,  15, 1'b1, 1'b0, 12'h015};
    vecs[2]  = '{8'h64, 8'h32, 2'b00, 1'b0, 1'b0, 127, 1'b0, 1'b1, 12'h127};
    vecs[3]  = '{8'hE4, 8'h32, 2'b01, 1'b0, 1'b0, 127, 1'b1, 1'b1, 12'h127};
    vecs[4]  = '{8'h00, 8'h1E, 2'b10, 1'b1, 1'b0,  30, 1'b0, 1'b0, 12'h030};
    vecs[5]  = '{8'h00, 8'h1E, 2'b10, 1'b0, 1'b0,  60, 1'b0, 1'b0, 12'h060};
    vecs[6]  = '{8'h00, 8'h1E, 2'b10, 1'b0, 1'b0,  90, 1'b0, 1'b0, 12'h090};
    vecs[7]  = '{8'h00, 8'h1E, 2'b10, 1'b0, 1'b0, 120, 1'b0, 1'b0, 12'h120};
    vecs[8]  = '{8'h00, 8'h1E, 2'b10, 1'b0, 1'b0, 127, 1'b0, 1'b1, 12'h127};
    vecs[9]  = '{8'h00, 8'h7F, 2'b11, 1'b0, 1'b0,   0, 1'b0, 1'b0, 12'h000};
    vecs[10] = '{8'h80, 8'h80, 2'b00, 1'b0, 1'b1,   0, 1'b0, 1'b0, 12'h000};

    key0 = 1'b1;
    key1 = 1'b1;
    a_sm = '0;
    b_sm = '0;
    mode = '0;
    #2 key0 = 1'b0;
    #4;
    check("reset.busy", 32'(busy), 0);
    check("reset.done", 32'(done), 0);
    check("reset.ovf", 32'(ovf), 0);
    check("reset.neg", 32'(neg), 0);
    check("reset.res_mag", 32'(res_mag), 0);
    check("reset.bcd", 32'(bcd), 0);
    @(negedge clk);
    key0 = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].rst_before) do_reset();
      apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].glitch);
      model_op(vecs[i].a, vecs[i].b, vecs[i].m, e_mag, e_neg, e_ovf, e_bcd);
      check_output($sformatf("vec%0d", i), vecs[i].e_mag, vecs[i].e_neg, vecs[i].e_ovf,
                   vecs[i].e_bcd);
    end

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rm = 2'($urandom_range(0, 3));
      model_op(ra, rb, rm, e_mag, e_neg, e_ovf, e_bcd);
      apply_stimulus(ra, rb, rm, 1'b0);
      check_output($sformatf("rand%0d", i), e_mag, e_neg, e_ovf, e_bcd);
    end

    // Abort during conversion: outputs clear immediately, partial result discarded.
    model_op(8'h19, 8'h8A, 2'b00, e_mag, e_neg, e_ovf, e_bcd);
    apply_stimulus(8'h19, 8'h8A, 2'b00, 1'b0);
    check_output("pre_abort", e_mag, e_neg, e_ovf, e_bcd);
    @(negedge clk);
    a_sm = 8'h64;
    b_sm = 8'h0A;
    mode = 2'b00;
    key1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    key1 = 1'b1;
    repeat (3) @(negedge clk);
    check("abort.busy_before", 32'(busy), 1);
    #1 key0 = 1'b0;
    key1 = 1'b0;
    #1;
    check("abort.busy", 32'(busy), 0);
    check("abort.done", 32'(done), 0);
    check("abort.res_mag", 32'(res_mag), 0);
    check("abort.bcd", 32'(bcd), 0);
    check("abort.neg", 32'(neg), 0);
    check("abort.ovf", 32'(ovf), 0);

    // key1 held low across reset release must not start an operation.
    @(negedge clk);
    key0 = 1'b1;
    model_acc = 0;
    busy_seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    check("held_key.busy_cycles", busy_seen, 0);
    key1 = 1'b1;
    @(negedge clk);

    model_op(8'h19, 8'h8A, 2'b00, e_mag, e_neg, e_ovf, e_bcd);
    apply_stimulus(8'h19, 8'h8A, 2'b00, 1'b0);
    check_output("post_reset", e_mag, e_neg, e_ovf, e_bcd);
    model_op(8'h00, 8'h05, 2'b10, e_mag, e_neg, e_ovf, e_bcd);
    apply_stimulus(8'h00, 8'h05, 2'b10, 1'b0);
    check_output("post_reset_acc", e_mag, e_neg, e_ovf, e_bcd);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
